// File: rtl/miner_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : miner_host_ctrl
// Description : Host DMA sequencer: reads NUM_LINES cache lines from the host
//               read region into a local buffer, then writes them back out to
//               the host write region.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_host_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 512,
    parameter int unsigned           NUM_LINES  = 4,
    parameter logic [ADDR_WIDTH-1:0] RD_OFFSET  = 64'h0,
    parameter logic [ADDR_WIDTH-1:0] WR_OFFSET  = 64'h1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_init,
    input  logic                  host_rd_ready,
    input  logic                  host_wr_ready,
    input  logic [ADDR_WIDTH-1:0] address_offset,
    input  logic [DATA_WIDTH-1:0] host_data_bus_read_in,
    output logic [DATA_WIDTH-1:0] host_data_bus_write_out,
    output logic [ADDR_WIDTH-1:0] corrected_address,
    output logic                  host_re,
    output logic                  host_we,
    output logic                  host_rgo,
    output logic                  host_wgo
);

    localparam int unsigned      c_CNT_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RGO   = 3'd1,
        S_READ  = 3'd2,
        S_WGO   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_rd_cnt;
    logic [c_CNT_W-1:0]      r_wr_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_buffer [NUM_LINES];

    logic                    w_rd_last;
    logic                    w_wr_last;

    assign w_rd_last         = (r_rd_cnt == c_LAST_IDX);
    assign w_wr_last         = (r_wr_cnt == c_LAST_IDX);
    assign corrected_address = r_addr;

    always_comb begin
        w_state_nxt             = r_state;
        host_rgo                = 1'b0;
        host_wgo                = 1'b0;
        host_re                 = 1'b0;
        host_we                 = 1'b0;
        host_data_bus_write_out = '0;
        case (r_state)
            S_IDLE: begin
                if (host_init) begin
                    w_state_nxt = S_RGO;
                end
            end
            S_RGO: begin
                host_rgo    = 1'b1;
                w_state_nxt = S_READ;
            end
            S_READ: begin
                host_re = host_rd_ready;
                if (host_rd_ready && w_rd_last) begin
                    w_state_nxt = S_WGO;
                end
            end
            S_WGO: begin
                host_wgo    = 1'b1;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                host_we                 = host_wr_ready;
                host_data_bus_write_out = r_buffer[r_wr_cnt];
                if (host_wr_ready && w_wr_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The base address is captured only at phase entry so software may
    // reprogram address_offset while a phase is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && host_init) begin
                r_addr   <= address_offset + RD_OFFSET;
                r_rd_cnt <= '0;
            end
            if (host_re) begin
                r_rd_cnt <= r_rd_cnt + c_CNT_W'(1);
                if (w_rd_last) begin
                    r_addr   <= address_offset + WR_OFFSET;
                    r_wr_cnt <= '0;
                end
            end
            if (host_we) begin
                r_wr_cnt <= r_wr_cnt + c_CNT_W'(1);
            end
        end
    end

    // Line storage carries no reset; it is always filled before being read.
    always_ff @(posedge clk) begin
        if (host_re) begin
            r_buffer[r_rd_cnt] <= host_data_bus_read_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miner_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_miner_host_ctrl
// Description : Directed self-checking bench for miner_host_ctrl with a
//               queue-based transfer model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miner_host_ctrl;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int NL = 4;
    localparam logic [AW-1:0] RD_OFF = 64'h0;
    localparam logic [AW-1:0] WR_OFF = 64'h1000;

    logic          clk;
    logic          rst_n;
    logic          host_init;
    logic          host_rd_ready;
    logic          host_wr_ready;
    logic [AW-1:0] address_offset;
    logic [DW-1:0] host_data_bus_read_in;
    logic [DW-1:0] host_data_bus_write_out;
    logic [AW-1:0] corrected_address;
    logic          host_re;
    logic          host_we;
    logic          host_rgo;
    logic          host_wgo;

    miner_host_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_LINES  (NL),
        .RD_OFFSET  (RD_OFF),
        .WR_OFFSET  (WR_OFF)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .host_init               (host_init),
        .host_rd_ready           (host_rd_ready),
        .host_wr_ready           (host_wr_ready),
        .address_offset          (address_offset),
        .host_data_bus_read_in   (host_data_bus_read_in),
        .host_data_bus_write_out (host_data_bus_write_out),
        .corrected_address       (corrected_address),
        .host_re                 (host_re),
        .host_we                 (host_we),
        .host_rgo                (host_rgo),
        .host_wgo                (host_wgo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int n_writes = 0;
    int wr_skip  = 0;

    function automatic logic [DW-1:0] data_of(input int n);
        return {8{64'hD0D0_0000_0000_0000 | 64'(n)}};
    endfunction

    // Host read data: the line offered is always the next one in the stream.
    always @(posedge clk) begin
        #1;
        host_data_bus_read_in = data_of(n_pops);
    end

    // Transfer model: phase 0 idle, 1 read-go, 2 reading, 3 write-go, 4 writing.
    int            m_phase = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_addr  = '0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (host_init) begin
                    m_phase = 1;
                    m_addr  = address_offset + RD_OFF;
                    m_q.delete();
                end
                1: m_phase = 2;
                2: if (host_rd_ready) begin
                    m_q.push_back(host_data_bus_read_in);
                    if (m_q.size() == NL) begin
                        m_phase = 3;
                        m_addr  = address_offset + WR_OFF;
                    end
                end
                3: m_phase = 4;
                4: if (host_wr_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus stream order of pushed lines.
    task automatic cyc();
        logic [DW-1:0] exp_wout;
        @(negedge clk);
        exp_wout = (m_phase == 4 && m_q.size() > 0) ? m_q[0] : '0;
        chk_a("m_addr", corrected_address, m_addr);
        chk_b("m_rgo", host_rgo, m_phase == 1);
        chk_b("m_wgo", host_wgo, m_phase == 3);
        chk_b("m_re", host_re, (m_phase == 2) && host_rd_ready);
        chk_b("m_we", host_we, (m_phase == 4) && host_wr_ready);
        chk_v("m_wout", host_data_bus_write_out, exp_wout);
        chk_b("re_we_excl", host_re & host_we, 1'b0);
        if (rst_n) begin
            if (host_re) n_pops++;
            if (host_we) begin
                chk_v("wdata_order", host_data_bus_write_out, data_of(n_writes + wr_skip));
                n_writes++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cyc();
        adv();
    endtask

    // Leaves the bench at the negedge where the model first sits in phase ph.
    task automatic to_phase(input int ph, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc();
            if (m_phase == ph) begin
                hit = 1'b1;
                break;
            end
            adv();
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_phase: actual %0d required %0d", m_phase, ph);
            cyc();
        end
    endtask

    int p0;
    int w0;

    initial begin
        rst_n          = 1'b0;
        host_init      = 1'b0;
        host_rd_ready  = 1'b0;
        host_wr_ready  = 1'b0;
        address_offset = '0;
        tick();
        cyc();
        chk_a("rst_addr", corrected_address, 64'h0);
        chk_v("rst_wout", host_data_bus_write_out, '0);
        chk_b("rst_rgo", host_rgo, 1'b0);
        adv();
        rst_n = 1'b1;
        tick();

        // Basic transfer with both ready inputs held high
        p0 = n_pops; w0 = n_writes;
        address_offset = 64'h4000;
        host_init = 1'b1; host_rd_ready = 1'b1; host_wr_ready = 1'b1;
        tick();
        host_init = 1'b0;
        cyc();
        chk_a("t1_rd_addr", corrected_address, 64'h4000);
        chk_b("t1_rgo", host_rgo, 1'b1);
        adv();
        cyc();
        chk_b("t1_rgo_once", host_rgo, 1'b0);
        adv();
        to_phase(3, 20);
        chk_i("t1_pops", n_pops - p0, 4);
        chk_a("t1_wr_addr", corrected_address, 64'h5000);
        chk_b("t1_wgo", host_wgo, 1'b1);
        adv();
        cyc();
        chk_b("t1_wgo_once", host_wgo, 1'b0);
        adv();
        to_phase(0, 20);
        chk_i("t1_writes", n_writes - w0, 4);
        adv();

        // Read ready toggling 1,0,1,0
        p0 = n_pops; w0 = n_writes;
        host_init = 1'b1; host_rd_ready = 1'b0;
        tick();
        host_init = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            host_rd_ready = (i % 2 == 0);
            tick();
        end
        host_rd_ready = 1'b0;
        to_phase(0, 20);
        chk_i("t2_pops", n_pops - p0, 4);
        chk_i("t2_writes", n_writes - w0, 4);
        adv();

        // Write stall for 10 cycles
        p0 = n_pops; w0 = n_writes;
        host_rd_ready = 1'b1; host_wr_ready = 1'b0; host_init = 1'b1;
        tick();
        host_init = 1'b0;
        to_phase(4, 20);
        adv();
        repeat (10) tick();
        cyc();
        chk_i("t3_stall_writes", n_writes - w0, 0);
        chk_v("t3_stall_wout", host_data_bus_write_out, data_of(p0));
        adv();
        host_wr_ready = 1'b1;
        to_phase(0, 20);
        chk_i("t3_writes", n_writes - w0, 4);
        adv();

        // Init during READ ignored; address sampled only at phase entry
        address_offset = 64'h8000; host_rd_ready = 1'b0; host_init = 1'b1;
        tick();
        host_init = 1'b0;
        to_phase(2, 10);
        adv();
        address_offset = 64'hC000; host_init = 1'b1;
        tick();
        tick();
        cyc();
        chk_a("t4_addr_held", corrected_address, 64'h8000);
        chk_b("t4_init_ignored", host_rgo, 1'b0);
        adv();
        host_init = 1'b0; host_rd_ready = 1'b1;
        to_phase(3, 20);
        chk_a("t4_wr_addr", corrected_address, 64'hD000);
        adv();
        address_offset = 64'h0;
        to_phase(0, 20);
        chk_a("t4_addr_after", corrected_address, 64'hD000);
        adv();

        // Init held high restarts straight from IDLE
        address_offset = 64'h4000; host_init = 1'b1;
        tick();
        to_phase(0, 20);
        chk_b("t5_idle_rgo", host_rgo, 1'b0);
        adv();
        cyc();
        chk_b("t5_restart_rgo", host_rgo, 1'b1);
        adv();
        host_init = 1'b0;
        to_phase(0, 20);
        adv();

        // Reset in the middle of WRITE
        host_init = 1'b1;
        tick();
        host_init = 1'b0;
        to_phase(4, 20);
        adv();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("t6_rst_we", host_we, 1'b0);
        chk_v("t6_rst_wout", host_data_bus_write_out, '0);
        chk_a("t6_rst_addr", corrected_address, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        wr_skip = n_pops - n_writes;
        tick();
        cyc();
        chk_b("t6_idle_after", host_rgo, 1'b0);
        chk_b("t6_no_we_after", host_we, 1'b0);
        adv();

        // Clean transfer after the abort
        p0 = n_pops; w0 = n_writes;
        host_init = 1'b1;
        tick();
        host_init = 1'b0;
        to_phase(0, 20);
        chk_i("t7_pops", n_pops - p0, 4);
        chk_i("t7_writes", n_writes - w0, 4);
        adv();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
